// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU decode/issue slice and the ALU itself.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU operation encodings, shared with the execute-stage ALU
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct7 values: base encoding and the alternate (SUB/SRA) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded operation as it sits in the ID/EX boundary
  typedef struct packed {
    alu_op_e             op;
    logic [XLEN-1:0]     in1;
    logic [XLEN-1:0]     in2;
    logic [4:0]          rd;
    logic                rd_we;
    logic                illegal;
  } issue_t;

  // Map funct3 to an ALU op; alt picks SUB over ADD and SRA over SRL
  function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of ALU-class RV32I instructions into ALU op, operands
// and writeback descriptor. Anything not handled here is flagged illegal with
// zeroed operands so the trap logic downstream sees a clean entry.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_t          dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode   = instr[6:0];
  assign rd_field = instr[11:7];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign shamt    = {27'b0, instr[24:20]};

  alu_op_e         op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            bad;

  // Decode opcode/funct fields into op and operands, then squash illegal ones
  always_comb begin
    op  = ALU_ADD;
    in1 = '0;
    in2 = '0;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        in1 = rs1_data;
        in2 = rs2_data;
        if (funct7 == F7_BASE) begin
          op = funct3_op(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          op = funct3_op(funct3, 1'b1);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        in1 = rs1_data;
        in2 = imm_i;
        case (funct3)
          3'b001: begin
            in2 = shamt;
            op  = ALU_SLL;
            bad = (funct7 != F7_BASE);
          end
          3'b101: begin
            in2 = shamt;
            if (funct7 == F7_BASE) begin
              op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              op = ALU_SRA;
            end else begin
              bad = 1'b1;
            end
          end
          default: op = funct3_op(funct3, 1'b0);
        endcase
      end
      OPC_LUI: begin
        in2 = imm_u;
      end
      OPC_AUIPC: begin
        in1 = pc;
        in2 = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op  = ALU_ADD;
      in1 = '0;
      in2 = '0;
    end
  end

  assign dec = '{op:      op,
                 in1:     in1,
                 in2:     in2,
                 rd:      rd_field,
                 rd_we:   !bad && (rd_field != 5'd0),
                 illegal: bad};

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes one instruction per cycle and registers it
// into the ID/EX boundary through a two-entry skid buffer. in_ready depends
// only on the skid valid bit, so there is no combinational path from out_ready.
module alu_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      ALUOp,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  issue_t dec;
  issue_t main_q, main_d;
  issue_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   consume;

  alu_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = main_valid_q && out_ready;

  // Skid-buffer next state: refill main from skid first, else from the input
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Main and skid entry registers with their valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign alu_in1   = main_q.in1;
  assign alu_in2   = main_q.in2;
  assign ALUOp     = main_q.op;
  assign rd        = main_q.rd;
  assign rd_we     = main_q.rd_we;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: hand-derived expected decodes are queued
// as instructions are offered and compared as the stage issues them.
module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  ALUOp;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  exp_t exp_q[$];
  exp_t act;
  exp_t want;
  int   checks = 0;
  int   errors = 0;

  alu_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .ALUOp     (ALUOp),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  assign act = {ALUOp, alu_in1, alu_in2, rd, rd_we, illegal};

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_instr = i;
    in_pc    = p;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
    end
    checks++;
    if (act !== '0) begin
      errors++;
      $display("[TB] FAIL reset_payload got %h want 0", act);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode;
    vec_t v[20];
    v[0]  = '{32'h002081B3, 32'h0, 32'd5, 32'd7, '{4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
    v[1]  = '{32'h40435293, 32'h0, 32'h80000000, 32'h0, '{4'h7, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0}};
    v[2]  = '{32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF, '{4'h0, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0}};
    v[3]  = '{32'h12345117, 32'h100, 32'hDEAD, 32'hBEEF, '{4'h0, 32'h100, 32'h12345000, 5'd2, 1'b1, 1'b0}};
    v[4]  = '{32'h40208233, 32'h0, 32'd9, 32'd4, '{4'h1, 32'd9, 32'd4, 5'd4, 1'b1, 1'b0}};
    v[5]  = '{32'hFFF40393, 32'h0, 32'h10, 32'hAAAA, '{4'h0, 32'h10, 32'hFFFFFFFF, 5'd7, 1'b1, 1'b0}};
    v[6]  = '{32'hFFFFFFFF, 32'h40, 32'd1, 32'd2, '{4'h0, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1}};
    v[7]  = '{32'h00100013, 32'h0, 32'h55, 32'h66, '{4'h0, 32'h55, 32'd1, 5'd0, 1'b0, 1'b0}};
    v[8]  = '{32'h023100B3, 32'h0, 32'd3, 32'd4, '{4'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1}};
    v[9]  = '{32'h40309113, 32'h0, 32'd3, 32'd4, '{4'h0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1}};
    v[10] = '{32'h007352B3, 32'h0, 32'hF0, 32'd4, '{4'h6, 32'hF0, 32'd4, 5'd5, 1'b1, 1'b0}};
    v[11] = '{32'h7FF53493, 32'h0, 32'h20, 32'h0, '{4'h9, 32'h20, 32'h7FF, 5'd9, 1'b1, 1'b0}};
    v[12] = '{32'h403140B3, 32'h0, 32'd3, 32'd4, '{4'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1}};
    v[13] = '{32'h00D675B3, 32'h0, 32'hFF, 32'h0F, '{4'h4, 32'hFF, 32'h0F, 5'd11, 1'b1, 1'b0}};
    v[14] = '{32'h003120B3, 32'h0, 32'd1, 32'd2, '{4'h8, 32'd1, 32'd2, 5'd1, 1'b1, 1'b0}};
    v[15] = '{32'hFF016093, 32'h0, 32'h1234, 32'h0, '{4'h3, 32'h1234, 32'hFFFFFFF0, 5'd1, 1'b1, 1'b0}};
    v[16] = '{32'h003110B3, 32'h0, 32'd1, 32'd3, '{4'h5, 32'd1, 32'd3, 5'd1, 1'b1, 1'b0}};
    v[17] = '{32'h00000063, 32'h0, 32'd1, 32'd3, '{4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}};
    v[18] = '{32'h01F15093, 32'h0, 32'hFFFF0000, 32'h0, '{4'h6, 32'hFFFF0000, 32'd31, 5'd1, 1'b1, 1'b0}};
    v[19] = '{32'h60435293, 32'h0, 32'h80000000, 32'h0, '{4'h0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1}};
    out_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL decode_valid[%0d] got %0b want 1", i - 1, out_valid);
        end
        want = exp_q.pop_front();
        checks++;
        if (act !== want) begin
          errors++;
          $display("[TB] FAIL decode_payload[%0d] got %h want %h", i - 1, act, want);
        end
      end
      if (i < 20) begin
        drive(1'b1, v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
        exp_q.push_back(v[i].exp);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL decode_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    exp_q.push_back('{4'h0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0});
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || act !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL stall_first got rdy=%0b vld=%0b %h want rdy=1 vld=1 %h", in_ready, out_valid, act, exp_q[0]);
    end
    drive(1'b1, 32'h40208233, 32'h0, 32'd10, 32'd3);
    exp_q.push_back('{4'h1, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0});
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || act !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL stall_full got rdy=%0b %h want rdy=0 %h", in_ready, act, exp_q[0]);
    end
    drive(1'b1, 32'h00D675B3, 32'h0, 32'hF, 32'd3);
    exp_q.push_back('{4'h4, 32'hF, 32'd3, 5'd11, 1'b1, 1'b0});
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_hold_ready got %0b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || act !== want) begin
        errors++;
        $display("[TB] FAIL drain_order[%0d] got vld=%0b %h want vld=1 %h", k, out_valid, act, want);
      end
      if (k == 2) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_empty got vld=%0b q=%0d want vld=0 q=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    @(negedge clk);
    drive(1'b1, 32'h40208233, 32'h0, 32'd3, 32'd4);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_full_ready got %0b want 0", in_ready);
    end
    drive(1'b1, 32'h00D675B3, 32'h0, 32'd5, 32'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_clear got vld=%0b rdy=%0b want vld=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_stale[%0d] got %0b want 0", k, out_valid);
      end
    end
    drive(1'b1, 32'h003120B3, 32'h0, 32'd7, 32'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_drop_accept got %0b want 0", out_valid);
    end
    drive(1'b1, 32'h003110B3, 32'h0, 32'd9, 32'd2);
    exp_q.push_back('{4'h5, 32'd9, 32'd2, 5'd1, 1'b1, 1'b0});
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    want = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || act !== want) begin
      errors++;
      $display("[TB] FAIL flush_after got vld=%0b %h want vld=1 %h", out_valid, act, want);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_after_idle got %0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    @(negedge clk);
    drive(1'b1, 32'h40208233, 32'h0, 32'd3, 32'd4);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || act !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async got vld=%0b rdy=%0b %h want vld=0 rdy=1 0", out_valid, in_ready, act);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_stale got %0b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [4:0]  rdv;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdv = 5'($urandom_range(0, 31));
      sub = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      if (c < 360) begin
        drive(1'($urandom_range(0, 1)), {1'b0, sub, 5'b0, 5'd2, 5'd1, 3'b000, rdv, 7'h33}, 32'h0, a, b);
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL random_extra got %h want nothing", act);
        end else begin
          want = exp_q.pop_front();
          if (act !== want) begin
            errors++;
            $display("[TB] FAIL random_payload[%0d] got %h want %h", c, act, want);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{sub ? 4'h1 : 4'h0, a, b, rdv, rdv != 5'd0, 1'b0});
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL random_drain got q=%0d vld=%0b want q=0 vld=0", exp_q.size(), out_valid);
    end
  endtask

  // Run each scenario in order and print the summary
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage for the RV32I integer datapath. It accepts one fetched instruction per cycle with its PC and register-file read data, and decodes the ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into the 4-bit ALU opcode, two operands and a writeback descriptor. Results are registered into the ID/EX boundary behind a two-entry skid buffer with valid/ready handshakes on both sides. The registered outputs drive the ALU inputs directly.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- rs1_data  in  32  register-file read of instr[19:15], same cycle as in_valid.
- rs2_data  in  32  register-file read of instr[24:20], same cycle as in_valid.
- flush  in  1  discard everything held and anything accepted this cycle.
- out_valid  out  1  issued operation valid.
- out_ready  in  1  downstream consumes when out_valid&&out_ready.
- alu_in1  out  32  first ALU operand.
- alu_in2  out  32  second ALU operand.
- ALUOp  out  4  ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- rd  out  5  destination register.
- rd_we  out  1  writeback enable; forced 0 when rd==0 or illegal.
- illegal  out  1  instruction is not an ALU-class instruction handled here.

## Operation
- OP (0110011): in1=rs1_data, in2=rs2_data. Opcode selected by funct3 (000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND).
  - funct7=0100000 selects SUB or SRA; valid only with funct3 000 or 101.
  - Any other funct7 except 0000000 is illegal.
- OP-IMM (0010011): in1=rs1_data, in2=sign-extended I-immediate. funct3 decodes as for OP; no SUBI.
  - SLLI requires funct7=0000000.
  - SRLI requires funct7=0000000; SRAI requires funct7=0100000.
  - For shifts, in2 = zero-extended shamt (instr[24:20]).
- LUI: in1=0, in2={instr[31:12],12'b0}, ADD.
- AUIPC: in1=in_pc, in2={instr[31:12],12'b0}, ADD.
- Any other opcode or illegal encoding: illegal=1, ALUOp=ADD, in1=in2=0, rd_we=0. The entry is still issued (out_valid=1) so the trap logic downstream sees it in order.
- Skid buffer:
  - Registers: main entry (out_*) and skid entry, each with a valid bit.
  - Accept on in_valid&&in_ready&&!flush.
  - Accepted data goes to main if main is empty or is being consumed this cycle; otherwise it goes to skid.
  - When main is consumed and skid is valid, skid moves to main.
  - Order is strictly preserved.
- Flush: both valid bits clear at the next edge. Data accepted in the same cycle is dropped. in_ready is unaffected by flush in that cycle.

## Timing
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Throughput: 1 per cycle while out_ready=1.
- in_ready is combinational from the skid valid bit only; no combinational path from out_ready.
- Reset values: out_valid=0, skid valid=0, in_ready=1, alu_in1=alu_in2=0, ALUOp=0000, rd=0, rd_we=0, illegal=0.
- Reset mid-operation discards both entries immediately.
- Output payload holds stable while out_valid&&!out_ready.
- Simultaneous consume and accept with skid empty: main reloads with the new entry; out_valid stays 1.

## Structure
- Shared package alu_pkg:
  - ALUOp encodings (ALU_ADD…ALU_SLTU), which the ALU also imports.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC.
  - funct7 constants F7_BASE, F7_ALT.
- One sub-module, alu_decode: purely combinational instruction-to-{ALUOp, in1, in2, rd, rd_we, illegal} decode.
- The alu_issue top holds only the skid-buffer registers and handshake logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, ALUOp=0000, in1=5, in2=7, rd=3, rd_we=1.
- SRAI x5,x6,4 (0x40435293), rs1=0x80000000 → ALUOp=0111, in2=4, rd=5; the ALU downstream returns 0xF8000000.
- LUI x1,0x12345 (0x123450B7) → ALUOp=0000, in1=0, in2=0x12345000. AUIPC with pc=0x100 → in1=0x100.
- out_ready=0, three back-to-back valid inputs A, B, C:
  - A and B are accepted; in_ready=0 in cycle 2; C is held upstream.
  - Raise out_ready → A, B, C emerge in order, with no bubble after B.
- Buffer full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and no stale entry appears later.
- 0xFFFFFFFF, then ADDI x0,x0,1 (0x00100013) → first: illegal=1, rd_we=0; second: illegal=0, rd_we=0 (rd=0).
